arm_banked_regfile: RTL

- Parametrised successor to the ARM7 banked register file.
- Configurable data width and read-port count; banking keyed on full 5-bit ARM CPSR mode field.
- Adds masked CPSR/SPSR writes, write-to-read bypass, and a hardware exception-entry sequencer (SPSR save, LR load, mode switch, vector load).
- Sits between decode/execute and writeback in the arm7 core.

---
 rtl/arm_banked_regfile.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/arm_banked_regfile.sv
// ARM banked register file: mode-banked GPRs, CPSR/SPSR with masked MSR,
// write-to-read bypass and a two-step hardware exception-entry sequencer.
module arm_banked_regfile #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [4*NUM_RD-1:0]      rd_addr,
    output logic [DATA_W*NUM_RD-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [3:0]               wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_restore,
    input  logic                     cpsr_wr_en,
    input  logic [3:0]               cpsr_wr_mask,
    input  logic [31:0]              cpsr_wr_data,
    input  logic                     spsr_wr_en,
    input  logic [3:0]               spsr_wr_mask,
    input  logic [31:0]              spsr_wr_data,
    output logic [31:0]              cpsr,
    output logic [31:0]              spsr,
    input  logic                     exc_req,
    input  logic [4:0]               exc_mode,
    input  logic [DATA_W-1:0]        exc_lr,
    input  logic [DATA_W-1:0]        exc_vector,
    output logic                     exc_busy,
    output logic                     exc_done
);

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    localparam logic [2:0] BANK_USR = 3'd0;
    localparam logic [2:0] BANK_FIQ = 3'd1;
    localparam logic [2:0] BANK_IRQ = 3'd2;
    localparam logic [2:0] BANK_SVC = 3'd3;
    localparam logic [2:0] BANK_ABT = 3'd4;
    localparam logic [2:0] BANK_UND = 3'd5;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SAVE   = 2'd1;
    localparam logic [1:0] ST_VECTOR = 2'd2;

    localparam logic [31:0] CPSR_RESET = 32'h0000_00D3;

    // USR, SYS and any unrecognised mode share the user bank
    function automatic logic [2:0] bank_of(input logic [4:0] m);
        case (m)
            MODE_FIQ: bank_of = BANK_FIQ;
            MODE_IRQ: bank_of = BANK_IRQ;
            MODE_SVC: bank_of = BANK_SVC;
            MODE_ABT: bank_of = BANK_ABT;
            MODE_UND: bank_of = BANK_UND;
            default:  bank_of = BANK_USR;
        endcase
    endfunction

    function automatic logic mode_legal(input logic [4:0] m);
        mode_legal = (m == MODE_USR) || (m == MODE_SYS) || (bank_of(m) != BANK_USR);
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  mask);
        merge_bytes = old_v;
        for (int unsigned i = 0; i < 4; i++) begin
            if (mask[i]) merge_bytes[8*i +: 8] = new_v[8*i +: 8];
        end
    endfunction

    logic [1:0]        state, state_nxt;
    logic              busy_nxt, done_nxt;

    logic [DATA_W-1:0] gpr_lo     [8];
    logic [DATA_W-1:0] gpr_usr_hi [5];
    logic [DATA_W-1:0] gpr_fiq_hi [5];
    logic [DATA_W-1:0] r13_bank   [6];
    logic [DATA_W-1:0] r14_bank   [6];
    logic [DATA_W-1:0] pc;
    // Entry 0 (user bank) is never written so USR/SYS read an SPSR of 0
    logic [31:0]       spsr_bank  [6];

    logic [4:0]        exc_mode_q;
    logic [DATA_W-1:0] exc_lr_q;
    logic [DATA_W-1:0] exc_vector_q;

    logic [DATA_W-1:0] view [16];
    logic [4:0]        cur_mode;
    logic [2:0]        cur_bank;
    logic [2:0]        exc_bank;
    logic [2:0]        hi_idx;
    logic              cur_priv, cur_exc, idle;
    logic              wr_go, restore_go, cpsr_go, spsr_go, exc_go;
    logic [DATA_W-1:0] wr_value;
    logic [3:0]        cpsr_mask_eff;
    logic [31:0]       cpsr_msr;
    logic              unused_bits;

    assign cur_mode   = cpsr[4:0];
    assign cur_bank   = bank_of(cur_mode);
    assign exc_bank   = bank_of(exc_mode_q);
    assign cur_exc    = (cur_bank != BANK_USR);
    assign cur_priv   = mode_legal(cur_mode) && (cur_mode != MODE_USR);
    assign idle       = (state == ST_IDLE);
    assign hi_idx     = 3'(wr_addr - 4'd8);

    assign wr_go      = wr_en && idle;
    assign restore_go = wr_go && wr_restore && (wr_addr == 4'd15) && cur_exc;
    assign cpsr_go    = cpsr_wr_en && idle;
    assign spsr_go    = spsr_wr_en && idle && cur_exc;
    assign exc_go     = idle && exc_req && (bank_of(exc_mode) != BANK_USR);
    assign wr_value   = (wr_addr == 4'd15) ? {wr_data[DATA_W-1:2], 2'b00} : wr_data;

    assign spsr        = spsr_bank[cur_bank];
    assign unused_bits = ^exc_vector[1:0];

    // Registers visible in the current mode, indexed by architectural number
    always_comb begin
        for (int unsigned i = 0; i < 8; i++) view[i] = gpr_lo[i];
        for (int unsigned i = 0; i < 5; i++) begin
            view[8+i] = (cur_bank == BANK_FIQ) ? gpr_fiq_hi[i] : gpr_usr_hi[i];
        end
        view[13] = r13_bank[cur_bank];
        view[14] = r14_bank[cur_bank];
        view[15] = pc;
    end

    // User mode may only touch the flags byte; illegal mode values leave byte 0 alone
    always_comb begin
        cpsr_mask_eff = cur_priv ? cpsr_wr_mask : {cpsr_wr_mask[3], 3'b000};
        cpsr_msr      = merge_bytes(cpsr, cpsr_wr_data, cpsr_mask_eff);
        if (cpsr_mask_eff[0] && !mode_legal(cpsr_wr_data[4:0])) begin
            cpsr_msr[7:0] = cpsr[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            exc_busy <= 1'b0;
            exc_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            exc_busy <= busy_nxt;
            exc_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (exc_go) state_nxt = ST_SAVE;
            ST_SAVE:   state_nxt = ST_VECTOR;
            ST_VECTOR: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
        done_nxt = (state_nxt == ST_VECTOR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) gpr_lo[i] <= '0;
            for (int unsigned i = 0; i < 5; i++) begin
                gpr_usr_hi[i] <= '0;
                gpr_fiq_hi[i] <= '0;
            end
            for (int unsigned i = 0; i < 6; i++) begin
                r13_bank[i]  <= '0;
                r14_bank[i]  <= '0;
                spsr_bank[i] <= '0;
            end
            pc           <= DATA_W'(RESET_PC);
            cpsr         <= CPSR_RESET;
            rd_data      <= '0;
            exc_mode_q   <= MODE_USR;
            exc_lr_q     <= '0;
            exc_vector_q <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_RD; p++) begin
                if ((BYPASS != 0) && wr_go && (wr_addr == rd_addr[4*p +: 4])) begin
                    rd_data[DATA_W*p +: DATA_W] <= wr_value;
                end else begin
                    rd_data[DATA_W*p +: DATA_W] <= view[rd_addr[4*p +: 4]];
                end
            end

            if (wr_go) begin
                if (!wr_addr[3]) begin
                    gpr_lo[wr_addr[2:0]] <= wr_value;
                end else if (wr_addr <= 4'd12) begin
                    if (cur_bank == BANK_FIQ) gpr_fiq_hi[hi_idx] <= wr_value;
                    else                      gpr_usr_hi[hi_idx] <= wr_value;
                end else if (wr_addr == 4'd13) begin
                    r13_bank[cur_bank] <= wr_value;
                end else if (wr_addr == 4'd14) begin
                    r14_bank[cur_bank] <= wr_value;
                end else begin
                    pc <= wr_value;
                end
            end

            if (cpsr_go) begin
                cpsr <= cpsr_msr;
            end else if (restore_go) begin
                cpsr <= spsr_bank[cur_bank];
            end

            if (spsr_go) begin
                spsr_bank[cur_bank] <= merge_bytes(spsr_bank[cur_bank], spsr_wr_data, spsr_wr_mask);
            end

            if (exc_go) begin
                exc_mode_q   <= exc_mode;
                exc_lr_q     <= exc_lr;
                exc_vector_q <= {exc_vector[DATA_W-1:2], 2'b00};
            end

            // Sequencer writes happen only while busy, when all port writes are dropped
            if (state == ST_SAVE) begin
                spsr_bank[exc_bank] <= cpsr;
                r14_bank[exc_bank]  <= exc_lr_q;
                cpsr <= {cpsr[31:8], 1'b1, (exc_mode_q == MODE_FIQ) | cpsr[6], 1'b0, exc_mode_q};
            end
            if (state == ST_VECTOR) begin
                pc <= exc_vector_q;
            end
        end
    end

endmodule
